exe_div_ctrl: RTL

- Sequencer for a multi-cycle iterative divider serving DIV/DIVU in the execute stage.
- Accepts operands from the execute stage and holds the pipeline via a stall request while iterating.
- Returns a 64-bit {remainder, quotient} result bound for HI/LO, alongside the existing single-cycle MULT path.
- Supports cancellation when the instruction in execute is annulled.

---
 rtl/exe_div_ctrl_pkg.sv | 15 +
 rtl/exe_div_ctrl_div_step.sv | 24 ++
 rtl/exe_div_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/exe_div_ctrl_pkg.sv
// Shared state codes and constants for the execute-stage divider sequencer.
package exe_div_ctrl_pkg;

   localparam int unsigned DIV_ITER   = 32;
   localparam int unsigned DIV_CNT_W  = 6;
   localparam logic        RST_ENABLE = 1'b0;

   typedef enum logic [1:0] {
      DivIdle    = 2'b00,
      DivDivzero = 2'b01,
      DivOn      = 2'b10,
      DivEnd     = 2'b11
   } div_state_e;

endpackage

// File: rtl/exe_div_ctrl_div_step.sv
// One restoring-division step: shift the dividend MSB into the partial remainder,
// trial-subtract the divisor and produce the quotient bit.
module exe_div_ctrl_div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] dvd_i,
   input  logic [DATA_W-1:0] dvs_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-2:0] dvd_o,
   output logic              q_o
);

   logic [DATA_W:0] trial;
   logic [DATA_W:0] diff;

   // One extra bit: the shifted remainder can reach 2*divisor-1.
   assign trial = {rem_i, dvd_i[DATA_W-1]};
   assign diff  = trial - {1'b0, dvs_i};
   assign q_o   = ~diff[DATA_W];
   assign rem_o = q_o ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
   assign dvd_o = dvd_i[DATA_W-2:0];

endmodule

// File: rtl/exe_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer with pipeline stall and annul support.
// Optional EXE_DIV_EARLY_TERM_EN: finish in two cycles when |dividend| < |divisor|.
module exe_div_ctrl
   import exe_div_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_ITER,
   parameter int unsigned CNT_W  = DIV_CNT_W
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst_n,
   input  logic                div_start_i,
   input  logic                div_signed_i,
   input  logic [DATA_W-1:0]   div_src1_i,
   input  logic [DATA_W-1:0]   div_src2_i,
   input  logic                div_annul_i,
   output logic                div_stall_o,
   output logic                div_ready_o,
   output logic [2*DATA_W-1:0] div_res_o
);

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                q_neg_q, q_neg_d;
   logic                r_neg_q, r_neg_d;
   logic [2*DATA_W-1:0] res_q, res_d;

   logic [DATA_W-1:0]   abs1, abs2;
   logic [DATA_W-1:0]   step_rem;
   logic [DATA_W-2:0]   step_dvd;
   logic                step_q;
   logic [DATA_W-1:0]   quot_full;
   logic                in_reset;

   assign in_reset = (cpu_rst_n == RST_ENABLE);
   assign abs1 = (div_signed_i && div_src1_i[DATA_W-1]) ? -div_src1_i : div_src1_i;
   assign abs2 = (div_signed_i && div_src2_i[DATA_W-1]) ? -div_src2_i : div_src2_i;
   assign quot_full = {step_dvd, step_q};

   exe_div_ctrl_div_step #(
      .DATA_W (DATA_W)
   ) u_div_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .dvd_o (step_dvd),
      .q_o   (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      res_d   = res_q;
      unique case (state_q)
         DivIdle: begin
            if (div_start_i && !div_annul_i) begin
               dvd_d   = abs1;
               dvs_d   = abs2;
               q_neg_d = div_signed_i & (div_src1_i[DATA_W-1] ^ div_src2_i[DATA_W-1]);
               r_neg_d = div_signed_i & div_src1_i[DATA_W-1];
               rem_d   = '0;
               cnt_d   = '0;
               if (div_src2_i == '0) begin
                  state_d = DivDivzero;
`ifdef EXE_DIV_EARLY_TERM_EN
               end else if (abs1 < abs2) begin
                  // Quotient is zero and the dividend already carries the remainder sign.
                  state_d = DivEnd;
                  res_d   = {div_src1_i, {DATA_W{1'b0}}};
`endif
               end else begin
                  state_d = DivOn;
               end
            end
         end
         DivOn: begin
            rem_d = step_rem;
            dvd_d = quot_full;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = DivEnd;
               res_d   = {r_neg_q ? -step_rem : step_rem, q_neg_q ? -quot_full : quot_full};
            end
         end
         DivDivzero: begin
            state_d = DivEnd;
            res_d   = '0;
         end
         DivEnd: begin
            state_d = DivIdle;
         end
         default: begin
            state_d = DivIdle;
         end
      endcase
      if (div_annul_i) begin
         state_d = DivIdle;
         cnt_d   = '0;
         res_d   = res_q;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (in_reset) begin
         state_q <= DivIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      div_stall_o = 1'b0;
      div_ready_o = 1'b0;
      div_res_o   = '0;
      if (!in_reset) begin
         div_res_o = res_q;
         if (!div_annul_i) begin
            div_stall_o = (state_q == DivOn) || (state_q == DivDivzero) ||
                          ((state_q == DivIdle) && div_start_i);
            div_ready_o = (state_q == DivEnd);
         end
      end
   end

endmodule
